lvds_ddr_serializer: RTL and testbench
======================================

LVDS_DDR_SERIALIZER -- requirements
Module: lvds_ddr_serializer

Interface
REQ-001 Parameter S, default 8: bits per word; SHALL be even, 4..16.
REQ-002 Parameter IDLE_WORD, default 0: word sent on underflow in stream mode.
REQ-003 dco_clk  input  1  single bit-pair clock; all logic on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  S  parallel word, MSB transmitted first.
REQ-006 in_valid  input  1  word offered.
REQ-007 in_ready  output  1  holding register can accept a word.
REQ-008 mode  input  2  0 stream, 1 fixed pattern, 2 ramp, 3 PRBS7.
REQ-009 pattern  input  S  word for mode 1.
REQ-010 slip_req  input  1  one-cycle pulse: delay data stream by one bit.
REQ-011 dout_rise, dout_fall  output  1 each  data bit pair for an external ODDR (rise = earlier bit).
REQ-012 dco_rise, dco_fall  output  1 each  forwarded clock pair, 1/0 after reset.
REQ-013 fco_rise, fco_fall  output  1 each  frame clock pair.
REQ-014 slip_offset  output  log2(S)  current bit delay 0..S-1.
REQ-015 underflow_cnt  output  16  saturating count of IDLE_WORD insertions.

Function
REQ-016 Phase counter 0..S/2-1 increments every cycle, wraps to 0; phase S/2-1 is the word boundary.
REQ-017 At the boundary a new word loads into cur; previous cur moves to prev; source per mode sampled that cycle.
REQ-018 Output window W = {prev, cur} (2S bits); with offset k and phase p, dout_rise = W bit (S-1+k-2p) counting from bit 0 of cur upward past S into prev, i.e. stream delayed by k bits; dout_fall = next lower bit.
REQ-019 Offset 0: phase 0 emits cur[S-1], cur[S-2]; phase S/2-1 emits cur[1], cur[0].
REQ-020 All dout/fco outputs registered; first bit of a loaded word appears the cycle after the boundary.
REQ-021 fco_rise = fco_fall = 1 for phases 0..S/4-1 bit-equivalents (first S/2 bits of word), 0 for the second half; fco is NOT affected by slip_offset.
REQ-022 slip_req latched as pending; at the next boundary offset = (offset+1) mod S; multiple pulses before one boundary count once.
REQ-023 Mode 0: one-entry holding register; in_ready = holding empty OR boundary-load this cycle; handshake in_valid&&in_ready writes holding.
REQ-024 Mode 0, boundary with holding empty and no same-cycle handshake: load IDLE_WORD, underflow_cnt +1, saturate at 16'hFFFF.
REQ-025 Mode 0, boundary with holding empty and same-cycle handshake: in_data bypasses directly into cur, no underflow.
REQ-026 Mode 1: load pattern. Mode 2: load ramp counter, counter +1 mod 2^S per boundary. Mode 3: load next S bits of PRBS7 (x^7+x^6+1, MSB = first generated bit), LFSR advances S steps per boundary.
REQ-027 Modes 1-3: in_ready = 0; holding contents retained; no underflow counting.
REQ-028 mode changes take effect only at a boundary; ramp and LFSR state persist across mode changes.

Reset
REQ-029 reset_n low: phase 0, cur/prev/holding 0, holding empty, offset 0, slip pending 0, ramp 0, LFSR 7'h7F, underflow_cnt 0.
REQ-030 During reset: dout/fco/dco outputs 0, in_ready 0; after release dco_rise=1, dco_fall=0 from first clock edge.
REQ-031 Reset mid-word discards partial word and holding content; no underflow counted for it.

Structure
REQ-032 Shared package holds mode encodings, PRBS7 polynomial/seed, default S.
REQ-033 One sub-module natural: prbs7_word_gen (S-step LFSR advance, combinational next state plus register).

Verification
REQ-034 S=8, mode 1, pattern 8'hA5, offset 0 -> serial stream 10100101 repeating, fco 11110000 per word.
REQ-035 Same, one slip_req -> after next boundary stream delayed 1 bit (…1 1010010 …), slip_offset 1; 8 pulses -> offset wraps to 0.
REQ-036 Mode 0, words 8'h01,8'h02,8'h03 back-to-back -> emitted in order, no gaps, underflow_cnt 0; then stop in_valid -> IDLE_WORD emitted, underflow_cnt increments once per word.
REQ-037 Mode 2 -> successive words 00,01,02…FF,00; mode 3 -> 127-bit repeating PRBS7 stream matching reference model.
REQ-038 reset_n asserted at phase 2 with holding full -> all outputs 0 asynchronously; after release in_ready=1, offset 0, underflow_cnt 0.

Source files
------------

// File: rtl/lvds_ddr_serializer_pkg.sv
// Shared constants for the LVDS DDR serializer: source mode encodings,
// PRBS7 polynomial/seed and the default word width.
package lvds_ddr_serializer_pkg;

    localparam int S_DEFAULT = 8;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_STREAM  = 2'd0;
    localparam mode_t MODE_PATTERN = 2'd1;
    localparam mode_t MODE_RAMP    = 2'd2;
    localparam mode_t MODE_PRBS7   = 2'd3;

    // x^7 + x^6 + 1: feedback taps on the two oldest bits
    localparam logic [6:0] PRBS7_TAPS = 7'h60;
    localparam logic [6:0] PRBS7_SEED = 7'h7F;

    function automatic logic prbs7_fb(input logic [6:0] state);
        return ^(state & PRBS7_TAPS);
    endfunction

endpackage

// File: rtl/lvds_ddr_serializer_prbs7_word_gen.sv
// PRBS7 word source: exposes the next S generated bits (first bit in the MSB)
// and advances the LFSR by S steps when a word is taken.
module prbs7_word_gen
    import lvds_ddr_serializer_pkg::*;
#(
    parameter int S = S_DEFAULT
) (
    input  logic         dco_clk,
    input  logic         reset_n,
    input  logic         advance,
    output logic [S-1:0] word
);

    logic [6:0] lfsr_q;
    logic [6:0] lfsr_nx;

    always_comb begin
        lfsr_nx = lfsr_q;
        word    = '0;
        for (int i = S - 1; i >= 0; i--) begin
            word[i] = prbs7_fb(lfsr_nx);
            lfsr_nx = {lfsr_nx[5:0], word[i]};
        end
    end

    always_ff @(posedge dco_clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= PRBS7_SEED;
        end else if (advance) begin
            lfsr_q <= lfsr_nx;
        end
    end

endmodule

// File: rtl/lvds_ddr_serializer.sv
// S-bit word to DDR bit-pair serializer with stream/pattern/ramp/PRBS7 sources,
// bit-slip alignment and forwarded data/frame clock pairs.
module lvds_ddr_serializer
    import lvds_ddr_serializer_pkg::*;
#(
    parameter int          S         = S_DEFAULT,
    parameter logic [S-1:0] IDLE_WORD = '0
) (
    input  logic                 dco_clk,
    input  logic                 reset_n,
    input  logic [S-1:0]         in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           mode,
    input  logic [S-1:0]         pattern,
    input  logic                 slip_req,
    output logic                 dout_rise,
    output logic                 dout_fall,
    output logic                 dco_rise,
    output logic                 dco_fall,
    output logic                 fco_rise,
    output logic                 fco_fall,
    output logic [$clog2(S)-1:0] slip_offset,
    output logic [15:0]          underflow_cnt
);

    localparam int PW = $clog2(S / 2);
    localparam int OW = $clog2(S);
    localparam int IW = $clog2(2 * S) + 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(S / 2 - 1);

    logic [PW-1:0] phase_q, phase_nx;
    logic [S-1:0]  cur_q, cur_nx, prev_q, prev_nx, hold_q, hold_nx, ramp_q, ramp_nx;
    logic          hold_vld_q, hold_vld_nx, pend_q, pend_nx;
    logic [OW-1:0] off_q, off_nx;
    logic [15:0]   ucnt_q, ucnt_nx;
    mode_t         mode_q, act_mode;
    logic          boundary, hs, prbs_adv;
    logic [S-1:0]  prbs_word;

    logic [2*S-1:0] window_nx, window_sh;
    logic [IW-1:0]  fall_idx, bit_pos;

    prbs7_word_gen #(.S(S)) u_prbs (
        .dco_clk (dco_clk),
        .reset_n (reset_n),
        .advance (prbs_adv),
        .word    (prbs_word)
    );

    // Mode is only honoured at a word boundary; between boundaries the last one holds.
    assign boundary = (phase_q == LAST_PHASE);
    assign act_mode = boundary ? mode : mode_q;
    assign in_ready = reset_n && (act_mode == MODE_STREAM) && (!hold_vld_q || boundary);
    assign hs       = in_valid && in_ready;

    always_comb begin
        phase_nx    = boundary ? '0 : phase_q + PW'(1);
        cur_nx      = cur_q;
        prev_nx     = prev_q;
        hold_nx     = hold_q;
        hold_vld_nx = hold_vld_q;
        ramp_nx     = ramp_q;
        ucnt_nx     = ucnt_q;
        off_nx      = off_q;
        pend_nx     = pend_q | slip_req;
        prbs_adv    = 1'b0;
        if (hs) begin
            hold_nx     = in_data;
            hold_vld_nx = 1'b1;
        end
        if (boundary) begin
            prev_nx = cur_q;
            if (pend_nx) begin
                off_nx  = (off_q == OW'(S - 1)) ? '0 : off_q + OW'(1);
                pend_nx = 1'b0;
            end
            case (mode)
                MODE_STREAM: begin
                    if (hold_vld_q) begin
                        cur_nx      = hold_q;
                        hold_vld_nx = hs;
                    end else if (hs) begin
                        cur_nx      = in_data;
                        hold_vld_nx = 1'b0;
                    end else begin
                        cur_nx = IDLE_WORD;
                        if (ucnt_q != 16'hFFFF) ucnt_nx = ucnt_q + 16'd1;
                    end
                end
                MODE_PATTERN: cur_nx = pattern;
                MODE_RAMP: begin
                    cur_nx  = ramp_q;
                    ramp_nx = ramp_q + S'(1);
                end
                default: begin
                    cur_nx   = prbs_word;
                    prbs_adv = 1'b1;
                end
            endcase
        end
    end

    // Select the pair from the post-edge window so a freshly loaded word shows up
    // on the very next cycle. Higher window bits are older, so +offset delays.
    always_comb begin
        window_nx = {prev_nx, cur_nx};
        fall_idx  = IW'(S - 2) + IW'(off_nx) - (IW'(phase_nx) << 1);
        window_sh = window_nx >> fall_idx;
        bit_pos   = IW'(phase_nx) << 1;
    end

    always_ff @(posedge dco_clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q    <= '0;
            cur_q      <= '0;
            prev_q     <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            ramp_q     <= '0;
            off_q      <= '0;
            pend_q     <= 1'b0;
            ucnt_q     <= '0;
            mode_q     <= MODE_STREAM;
        end else begin
            phase_q    <= phase_nx;
            cur_q      <= cur_nx;
            prev_q     <= prev_nx;
            hold_q     <= hold_nx;
            hold_vld_q <= hold_vld_nx;
            ramp_q     <= ramp_nx;
            off_q      <= off_nx;
            pend_q     <= pend_nx;
            ucnt_q     <= ucnt_nx;
            if (boundary) mode_q <= mode;
        end
    end

    // Output register stage
    always_ff @(posedge dco_clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_rise <= 1'b0;
            dout_fall <= 1'b0;
            fco_rise  <= 1'b0;
            fco_fall  <= 1'b0;
            dco_rise  <= 1'b0;
            dco_fall  <= 1'b0;
        end else begin
            dout_rise <= window_sh[1];
            dout_fall <= window_sh[0];
            fco_rise  <= (bit_pos < IW'(S / 2));
            fco_fall  <= ((bit_pos + IW'(1)) < IW'(S / 2));
            dco_rise  <= 1'b1;
            dco_fall  <= 1'b0;
        end
    end

    assign slip_offset   = off_q;
    assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_lvds_ddr_serializer.sv
// Randomized bench for lvds_ddr_serializer: models the transmitted bit stream as
// a list of words, replayed MSB-first and delayed by the current slip offset.
module tb_lvds_ddr_serializer;

    localparam int         S    = 8;
    localparam logic [7:0] IDLE = 8'h3C;

    logic       dco_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] mode = 2'd0;
    logic [7:0] pattern = '0;
    logic       slip_req = 1'b0;
    logic       dout_rise, dout_fall, dco_rise, dco_fall, fco_rise, fco_fall;
    logic [2:0] slip_offset;
    logic [15:0] underflow_cnt;

    lvds_ddr_serializer #(.S(S), .IDLE_WORD(IDLE)) dut (
        .dco_clk       (dco_clk),
        .reset_n       (reset_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mode          (mode),
        .pattern       (pattern),
        .slip_req      (slip_req),
        .dout_rise     (dout_rise),
        .dout_fall     (dout_fall),
        .dco_rise      (dco_rise),
        .dco_fall      (dco_fall),
        .fco_rise      (fco_rise),
        .fco_fall      (fco_fall),
        .slip_offset   (slip_offset),
        .underflow_cnt (underflow_cnt)
    );

    always #5 dco_clk = ~dco_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int         e;          // rising edges since reset release
    logic [7:0] words[$];   // every word that entered the output register, in order
    logic [7:0] hq[$];      // accepted but not yet transmitted stream words
    logic [7:0] offer[$];   // directed words to present on in_data
    logic       prbs_h[$];  // last seven PRBS7 bits, oldest first
    int         k;
    logic       pend;
    int         ucnt;
    logic [7:0] ramp;
    logic [1:0] last_mode;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
        end
    endtask

    function automatic logic exp_bit(input int idx);
        logic [7:0] w;
        if (idx < 0) return 1'b0;
        w = words[idx / 8];
        return w[7 - (idx % 8)];
    endfunction

    function automatic logic [7:0] prbs_word();
        logic [7:0] w;
        logic       b;
        for (int i = 7; i >= 0; i--) begin
            b = prbs_h[0] ^ prbs_h[1];
            prbs_h.push_back(b);
            void'(prbs_h.pop_front());
            w[i] = b;
        end
        return w;
    endfunction

    task automatic model_reset();
        e = 0; k = 0; pend = 1'b0; ucnt = 0; ramp = '0; last_mode = 2'd0;
        words.delete(); hq.delete(); offer.delete(); prbs_h.delete();
        words.push_back(8'h00);
        for (int i = 0; i < 7; i++) prbs_h.push_back(1'b1);
    endtask

    task automatic check_outputs();
        int p;
        if (e == 0) begin
            check_eq("dout_rise_rst", 32'(dout_rise), 32'd0);
            check_eq("dout_fall_rst", 32'(dout_fall), 32'd0);
            check_eq("fco_rst", {30'd0, fco_rise, fco_fall}, 32'd0);
            check_eq("dco_rst", {30'd0, dco_rise, dco_fall}, 32'd0);
        end else begin
            p = e % 4;
            check_eq("dout_rise", 32'(dout_rise), 32'(exp_bit(2 * e - k)));
            check_eq("dout_fall", 32'(dout_fall), 32'(exp_bit(2 * e + 1 - k)));
            check_eq("fco_rise", 32'(fco_rise), 32'(2 * p < S / 2));
            check_eq("fco_fall", 32'(fco_fall), 32'(2 * p + 1 < S / 2));
            check_eq("dco", {30'd0, dco_rise, dco_fall}, 32'd2);
        end
        check_eq("slip_offset", 32'(slip_offset), 32'(k));
        check_eq("underflow_cnt", 32'(underflow_cnt), 32'(ucnt));
    endtask

    task automatic tick(input logic [1:0] m, input int vpct, input int spct, input logic [7:0] pat);
        logic boundary, exp_ready, hs;
        logic [7:0] w;
        check_outputs();
        mode    = m;
        pattern = pat;
        if (offer.size() > 0) begin
            in_valid = 1'b1;
            in_data  = offer[0];
        end else begin
            in_valid = ($urandom_range(99) < 32'(vpct));
            in_data  = 8'($urandom);
        end
        slip_req = (e % 4 != 3) && ($urandom_range(99) < 32'(spct));
        #1;
        boundary  = (e % 4 == 3);
        exp_ready = ((boundary ? m : last_mode) == 2'd0) && (hq.size() == 0 || boundary);
        check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
        hs = in_valid && exp_ready;
        if (hs) begin
            hq.push_back(in_data);
            if (offer.size() > 0) void'(offer.pop_front());
        end
        if (slip_req) pend = 1'b1;
        if (boundary) begin
            last_mode = m;
            if (pend) begin
                k    = (k + 1) % S;
                pend = 1'b0;
            end
            case (m)
                2'd0: begin
                    if (hq.size() > 0) w = hq.pop_front();
                    else begin
                        w = IDLE;
                        if (ucnt < 65535) ucnt++;
                    end
                end
                2'd1: w = pat;
                2'd2: begin
                    w    = ramp;
                    ramp = ramp + 8'd1;
                end
                default: w = prbs_word();
            endcase
            words.push_back(w);
        end
        @(negedge dco_clk);
        e++;
    endtask

    task automatic run(input int n, input logic [1:0] m, input int vpct, input int spct,
                       input logic [7:0] pat);
        for (int c = 0; c < n; c++) tick(m, vpct, spct, pat);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        slip_req = 1'b0;
        #1;
        check_eq("rst_dout", {30'd0, dout_rise, dout_fall}, 32'd0);
        check_eq("rst_fco", {30'd0, fco_rise, fco_fall}, 32'd0);
        check_eq("rst_dco", {30'd0, dco_rise, dco_fall}, 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_offset", 32'(slip_offset), 32'd0);
        check_eq("rst_ucnt", 32'(underflow_cnt), 32'd0);
        @(negedge dco_clk);
        @(negedge dco_clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        @(negedge dco_clk);
        do_reset();

        // fixed pattern, no slip, then random slips incl. several pulses per word
        run(40, 2'd1, 0, 0, 8'hA5);
        run(200, 2'd1, 0, 10, 8'hA5);
        run(60, 2'd1, 0, 60, 8'hC3);

        // back-to-back stream words then underflow
        do_reset();
        offer.push_back(8'h01);
        offer.push_back(8'h02);
        offer.push_back(8'h03);
        run(48, 2'd0, 0, 0, 8'h00);
        run(300, 2'd0, 50, 5, 8'h00);

        // ramp through a full wrap, then PRBS7 over many periods
        run(1100, 2'd2, 30, 3, 8'h00);
        run(600, 2'd3, 30, 3, 8'h00);

        // mode switches at arbitrary phases
        for (int r = 0; r < 25; r++)
            run(int'($urandom_range(3, 20)), 2'($urandom), 60, 5, 8'($urandom));

        // reset at phase 2 with the holding register full
        run(8, 2'd0, 100, 0, 8'h00);
        while (e % 4 != 2) tick(2'd0, 100, 0, 8'h00);
        do_reset();
        run(60, 2'd0, 50, 10, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got %0d tests expected completion", n_tests);
        $fatal(1);
    end

endmodule
